alu_instr_encoder: RTL
======================

ALU_INSTR_ENCODER -- requirements
Module: alu_instr_encoder

Interface
REQ-001 The block SHALL have exactly one clock domain: clk, with reset rst_n asynchronous and active-low.
REQ-002 Port clk, input, 1: rising-edge clock.
REQ-003 Port rst_n, input, 1: asynchronous active-low reset.
REQ-004 Port req_valid, input, 1: the request fields are valid.
REQ-005 Port req_ready, output, 1: the block can accept a request.
REQ-006 Port req_alu_op, input, 4: ALU control code, legal range 0x0-0x9.
REQ-007 Port req_imm_sel, input, 1: 1 selects I-type (OP-IMM) encoding; 0 selects R-type (OP).
REQ-008 Ports req_rd, req_rs1 and req_rs2, input, 5 each: register indices; req_rs2 is ignored when req_imm_sel=1.
REQ-009 Port req_imm, input, 12: immediate; for shifts only bits [4:0] are used as shamt.
REQ-010 Port instr_valid, output, 1: instr holds an encoded word.
REQ-011 Port instr_ready, input, 1: the consumer accepts instr.
REQ-012 Port instr, output, 32: encoded RV32I instruction word.
REQ-013 Port level, output, 3: FIFO occupancy, 0-4.
REQ-014 Port err_sticky, output, 1: an illegal request has been seen since the last clear.
REQ-015 Port err_clr, input, 1: synchronous clear of err_sticky.

Function
REQ-016 The code map SHALL be as follows (code: funct3/funct7[5]):
- 0 ADD: 000/0
- 1 SUB: 000/1
- 2 SLL: 001/0
- 3 SLT: 010/0
- 4 SLTU: 011/0
- 5 XOR: 100/0
- 6 SRA: 101/1
- 7 SRL: 101/0
- 8 OR: 110/0
- 9 AND: 111/0
REQ-017 R-type encoding SHALL be {funct7,rs2,rs1,funct3,rd,7'b0110011}, with funct7 equal to 7'b0100000 when funct7[5]=1 and 0 otherwise.
REQ-018 I-type encoding SHALL be {imm[11:0],rs1,funct3,rd,7'b0010011}.
REQ-019 For I-type shifts (codes 2, 6, 7), imm[11:5] SHALL be replaced by the funct7 from REQ-016 and imm[4:0] SHALL be req_imm[4:0].
REQ-020 Codes 0xA-0xF SHALL be illegal, and code 1 with req_imm_sel=1 SHALL be illegal.
REQ-021 A request SHALL be accepted on any cycle where req_valid=1 and req_ready=1.
REQ-022 req_ready SHALL equal (level!=4), and it SHALL NOT depend on instr_ready (no full-bypass).
REQ-023 A legal accepted request SHALL be encoded and pushed into a 4-entry FIFO in the same cycle.
REQ-024 With an empty FIFO, instr_valid SHALL assert on the cycle after acceptance (latency 1).
REQ-025 The FIFO head SHALL drive instr, and instr_valid SHALL equal (level!=0).
REQ-026 instr SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-027 A pop SHALL occur when instr_valid=1 and instr_ready=1.
REQ-028 A simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-029 Read and write pointers SHALL be 2 bits and wrap modulo 4.
REQ-030 An illegal accepted request SHALL set err_sticky on the next edge and SHALL NOT be pushed, except as given in REQ-037.
REQ-031 When err_clr=1 and an illegal acceptance occur in the same cycle, the set SHALL win.
REQ-032 instr SHALL read 0x00000000 when level=0.

Reset
REQ-033 Asserting rst_n low SHALL immediately force level=0, instr_valid=0, instr=0, err_sticky=0, pointers=0 and req_ready=0.
REQ-034 req_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-035 A reset asserted mid-operation SHALL discard all FIFO contents, with no partial pop.

Configuration
REQ-036 The macro ALU_ENC_ILLEGAL_NOP_EN SHALL select how illegal requests are handled.
REQ-037 With ALU_ENC_ILLEGAL_NOP_EN defined, an illegal request SHALL push the canonical NOP 0x00000013 (ADDI x0,x0,0) and set err_sticky.
REQ-038 Without ALU_ENC_ILLEGAL_NOP_EN, an illegal request SHALL be dropped and only set err_sticky.

Verification
REQ-039 Scenario R-type: ADD rd=1, rs1=2, rs2=3, imm_sel=0 -> instr=0x003100B3 one cycle later; SUB rd=5, rs1=6, rs2=7 -> 0x407302B3.
REQ-040 Scenario I-type: SRA, imm_sel=1, rd=10, rs1=11, imm=0x003 -> 0x4035D513; ADD, imm_sel=1, rd=1, rs1=0, imm=0xFFF -> 0xFFF00093.
REQ-041 Scenario backpressure: instr_ready=0 with 5 back-to-back requests -> level reaches 4, req_ready=0 after the 4th, the 5th is held; instr_ready=1 -> words drain in order and the 5th is accepted.
REQ-042 Scenario illegal: code 0xC -> err_sticky=1 and level unchanged (macro off) or NOP 0x00000013 pushed (macro on); err_clr=1 -> err_sticky=0.
REQ-043 Scenario concurrent push/pop: level=2 with push and pop in the same cycle -> level stays 2 and the output order is correct.
REQ-044 Scenario reset mid-operation: level=3, then rst_n low -> instr_valid=0 and level=0 asynchronously; first request after release -> output at latency 1.

Source files
------------

// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: RV32I OP/OP-IMM encoder feeding a 4-entry FIFO.
// Define ALU_ENC_ILLEGAL_NOP_EN to push a NOP for illegal requests instead of dropping them.
module alu_instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_alu_op,
  input  logic        req_imm_sel,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [11:0] req_imm,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [2:0]  level,
  output logic        err_sticky,
  input  logic        err_clr
);
`ifdef ALU_ENC_ILLEGAL_NOP_EN
  localparam logic NOP_EN = 1'b1;
`else
  localparam logic NOP_EN = 1'b0;
`endif
  logic [31:0] r_mem [4];
  logic [1:0]  r_wp, r_rp;
  logic [2:0]  r_level;
  logic        r_err, r_en;
  logic [2:0]  w_f3;
  logic        w_f7b, w_illegal, w_shift, w_acc, w_push, w_pop;
  logic [6:0]  w_f7;
  logic [11:0] w_imm;
  logic [31:0] w_word;
  always_comb begin
    w_f3  = 3'd0;
    w_f7b = 1'b0;
    case (req_alu_op)
      4'd1: w_f7b = 1'b1;
      4'd2: w_f3 = 3'd1;
      4'd3: w_f3 = 3'd2;
      4'd4: w_f3 = 3'd3;
      4'd5: w_f3 = 3'd4;
      4'd6: begin w_f3 = 3'd5; w_f7b = 1'b1; end
      4'd7: w_f3 = 3'd5;
      4'd8: w_f3 = 3'd6;
      4'd9: w_f3 = 3'd7;
      default: ;
    endcase
  end
  assign w_illegal = (req_alu_op > 4'd9) || (req_alu_op == 4'd1 && req_imm_sel);
  assign w_f7      = {1'b0, w_f7b, 5'b0};
  assign w_shift   = (w_f3 == 3'd1) || (w_f3 == 3'd5);
  assign w_imm     = w_shift ? {w_f7, req_imm[4:0]} : req_imm;
  assign w_word    = w_illegal   ? 32'h0000_0013 :
                     req_imm_sel ? {w_imm, req_rs1, w_f3, req_rd, 7'b0010011} :
                                   {w_f7, req_rs2, req_rs1, w_f3, req_rd, 7'b0110011};
  assign req_ready   = r_en && (r_level != 3'd4);
  assign instr_valid = (r_level != 3'd0);
  assign instr       = instr_valid ? r_mem[r_rp] : 32'h0;
  assign level       = r_level;
  assign err_sticky  = r_err;
  assign w_acc  = req_valid && req_ready;
  assign w_push = w_acc && (!w_illegal || NOP_EN);
  assign w_pop  = instr_valid && instr_ready;
  // r_en holds req_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_wp    <= 2'd0;
      r_rp    <= 2'd0;
      r_level <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_en    <= 1'b1;
      r_wp    <= r_wp + {1'b0, w_push};
      r_rp    <= r_rp + {1'b0, w_pop};
      r_level <= r_level + {2'b0, w_push} - {2'b0, w_pop};
      r_err   <= (w_acc && w_illegal) ? 1'b1 : err_clr ? 1'b0 : r_err;
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= w_word;
endmodule
